// File: rtl/clk_div_if.sv
// Control and status bundle for the programmable clock divider.
// The driver side (master) issues control; the divider (slave) reports status.
interface clk_div_if #(
  parameter int DIV_W = 32
);
  logic             en;
  logic             restart;
  logic             div_load;
  logic [DIV_W-1:0] div_in;
  logic             clk_out;
  logic             tick;
  logic             div_busy;
  logic [DIV_W-1:0] div_cur;

  modport master (
    output en, restart, div_load, div_in,
    input  clk_out, tick, div_busy, div_cur
  );

  modport slave (
    input  en, restart, div_load, div_in,
    output clk_out, tick, div_busy, div_cur
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider with a per-half-period tick.
// A reloaded divisor is held pending and only switched in at a half-period boundary.
module clk_div_prog #(
  parameter int          DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 10_000_000
) (
  input  logic    clk,
  input  logic    rst,
  clk_div_if.slave bus
);
  localparam logic [DIV_W-1:0] RST_DIV =
    (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] pending;
  logic             busy;
  logic             clk_out;
  logic             tick;
  logic [DIV_W-1:0] div_clamped;
  logic [DIV_W-1:0] div_next;
  logic             boundary;

  assign div_clamped = (bus.div_in == '0) ? DIV_W'(1) : bus.div_in;
  assign boundary    = (cnt == div_cur - DIV_W'(1));

  // Divisor taking effect at a boundary or restart: a same-edge load wins over pending.
  always_comb begin
    div_next = div_cur;
    if (bus.div_load)
      div_next = div_clamped;
    else if (busy)
      div_next = pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
      pending <= '0;
      div_cur <= RST_DIV;
    end else if (bus.restart) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
      div_cur <= div_next;
    end else if (bus.en) begin
      tick <= boundary;
      if (boundary) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        busy    <= 1'b0;
        div_cur <= div_next;
      end else begin
        cnt <= cnt + DIV_W'(1);
        if (bus.div_load) begin
          pending <= div_clamped;
          busy    <= 1'b1;
        end
      end
    end else begin
      tick <= 1'b0;
      if (bus.div_load) begin
        pending <= div_clamped;
        busy    <= 1'b1;
      end
    end
  end

  assign bus.clk_out  = clk_out;
  assign bus.tick     = tick;
  assign bus.div_busy = busy;
  assign bus.div_cur  = div_cur;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with DEFAULT_DIV=4; each step is one rising edge,
// outputs are sampled 1ns after it and inputs changed there for the following edge.
module tb_clk_div_prog;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  clk_div_if #(.DIV_W(W)) bus ();

  clk_div_prog #(.DIV_W(W), .DEFAULT_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Restart with an immediate divisor load, leaving cnt=0 and clk_out=0.
  task automatic restart_with(input logic [W-1:0] d);
    bus.restart  = 1'b1;
    bus.div_load = 1'b1;
    bus.div_in   = d;
    step();
    bus.restart  = 1'b0;
    bus.div_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.restart = 1'b1; bus.div_load = 1'b1; bus.div_in = 16'd9;
    step(); step();
    total++; if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out got=%b exp=0", bus.clk_out); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    total++; if (bus.div_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.div_busy); end
    total++; if (bus.div_cur !== 16'd4) begin bad++; $display("FAIL reset_div_cur got=%0d exp=4", bus.div_cur); end
    bus.restart = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;
  endtask

  task automatic test_basic();
    rst = 1'b1; bus.en = 1'b0;
    step(); step();
    rst = 1'b0; bus.en = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      total++; if (bus.clk_out !== 1'((e / 4) % 2)) begin bad++; $display("FAIL basic_clk_out edge=%0d got=%b exp=%b", e, bus.clk_out, 1'((e / 4) % 2)); end
      total++; if (bus.tick !== (e % 4 == 0)) begin bad++; $display("FAIL basic_tick edge=%0d got=%b exp=%b", e, bus.tick, (e % 4 == 0)); end
    end
    total++; if (bus.div_cur !== 16'd4) begin bad++; $display("FAIL basic_div_cur got=%0d exp=4", bus.div_cur); end
  endtask

  task automatic test_min_div();
    for (int v = 0; v < 2; v++) begin
      restart_with(16'(1 - v));
      total++; if (bus.div_cur !== 16'd1) begin bad++; $display("FAIL min_div_cur in=%0d got=%0d exp=1", 1 - v, bus.div_cur); end
      total++; if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL min_restart_clk_out got=%b exp=0", bus.clk_out); end
      for (int s = 1; s <= 6; s++) begin
        step();
        total++; if (bus.clk_out !== 1'(s % 2)) begin bad++; $display("FAIL min_clk_out in=%0d s=%0d got=%b exp=%b", 1 - v, s, bus.clk_out, 1'(s % 2)); end
        total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL min_tick in=%0d s=%0d got=%b exp=1", 1 - v, s, bus.tick); end
      end
    end
  endtask

  task automatic test_reload();
    logic exp_clk;
    restart_with(16'd5);
    for (int s = 1; s <= 11; s++) begin
      if (s == 1) begin bus.div_load = 1'b1; bus.div_in = 16'd3; end
      step();
      bus.div_load = 1'b0;
      exp_clk = (s >= 5 && s <= 7) || s >= 11;
      total++; if (bus.div_busy !== (s <= 4)) begin bad++; $display("FAIL reload_busy s=%0d got=%b exp=%b", s, bus.div_busy, (s <= 4)); end
      total++; if (bus.clk_out !== exp_clk) begin bad++; $display("FAIL reload_clk_out s=%0d got=%b exp=%b", s, bus.clk_out, exp_clk); end
      total++; if (bus.tick !== (s == 5 || s == 8 || s == 11)) begin bad++; $display("FAIL reload_tick s=%0d got=%b", s, bus.tick); end
      total++; if (bus.div_cur !== ((s < 5) ? 16'd5 : 16'd3)) begin bad++; $display("FAIL reload_div_cur s=%0d got=%0d", s, bus.div_cur); end
    end
  endtask

  task automatic test_double_load();
    restart_with(16'd4);
    bus.div_load = 1'b1; bus.div_in = 16'd7;
    step();
    bus.div_in = 16'd2;
    step();
    bus.div_load = 1'b0;
    total++; if (bus.div_busy !== 1'b1) begin bad++; $display("FAIL dbl_busy got=%b exp=1", bus.div_busy); end
    step(); step();
    total++; if (bus.div_cur !== 16'd2) begin bad++; $display("FAIL dbl_div_cur got=%0d exp=2", bus.div_cur); end
    total++; if (bus.clk_out !== 1'b1) begin bad++; $display("FAIL dbl_clk_out got=%b exp=1", bus.clk_out); end
    total++; if (bus.div_busy !== 1'b0) begin bad++; $display("FAIL dbl_busy_clr got=%b exp=0", bus.div_busy); end
    step();
    bus.div_load = 1'b1; bus.div_in = 16'd3;
    step();
    bus.div_load = 1'b0;
    total++; if (bus.div_cur !== 16'd3) begin bad++; $display("FAIL bnd_div_cur got=%0d exp=3", bus.div_cur); end
    total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL bnd_tick got=%b exp=1", bus.tick); end
    total++; if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL bnd_clk_out got=%b exp=0", bus.clk_out); end
    for (int s = 1; s <= 3; s++) begin
      total++; if (bus.div_busy !== 1'b0) begin bad++; $display("FAIL bnd_busy s=%0d got=%b exp=0", s, bus.div_busy); end
      step();
    end
    total++; if (bus.clk_out !== 1'b1) begin bad++; $display("FAIL bnd_next_toggle got=%b exp=1", bus.clk_out); end
  endtask

  task automatic test_enable_gating();
    restart_with(16'd4);
    step(); step();
    bus.en = 1'b0;
    bus.div_load = 1'b1; bus.div_in = 16'd2;
    for (int s = 1; s <= 3; s++) begin
      step();
      bus.div_load = 1'b0;
      total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL gate_tick s=%0d got=%b exp=0", s, bus.tick); end
      total++; if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL gate_clk_out s=%0d got=%b exp=0", s, bus.clk_out); end
    end
    total++; if (bus.div_busy !== 1'b1) begin bad++; $display("FAIL gate_busy got=%b exp=1", bus.div_busy); end
    bus.en = 1'b1;
    step();
    total++; if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL gate_resume1 got=%b exp=0", bus.clk_out); end
    step();
    total++; if (bus.clk_out !== 1'b1 || bus.tick !== 1'b1) begin bad++; $display("FAIL gate_resume2 clk_out=%b tick=%b exp=1,1", bus.clk_out, bus.tick); end
    total++; if (bus.div_cur !== 16'd2 || bus.div_busy !== 1'b0) begin bad++; $display("FAIL gate_apply div_cur=%0d busy=%b exp=2,0", bus.div_cur, bus.div_busy); end
  endtask

  task automatic test_restart_reset();
    restart_with(16'd4);
    for (int s = 1; s <= 5; s++) step();
    total++; if (bus.clk_out !== 1'b1) begin bad++; $display("FAIL rst_pre_clk_out got=%b exp=1", bus.clk_out); end
    restart_with(16'd6);
    total++; if (bus.clk_out !== 1'b0 || bus.tick !== 1'b0) begin bad++; $display("FAIL rs_out clk_out=%b tick=%b exp=0,0", bus.clk_out, bus.tick); end
    total++; if (bus.div_cur !== 16'd6) begin bad++; $display("FAIL rs_div_cur got=%0d exp=6", bus.div_cur); end
    for (int s = 1; s <= 6; s++) begin
      step();
      total++; if (bus.clk_out !== (s == 6)) begin bad++; $display("FAIL rs_rise s=%0d got=%b exp=%b", s, bus.clk_out, (s == 6)); end
    end
    bus.div_load = 1'b1; bus.div_in = 16'd7;
    step();
    bus.div_load = 1'b0;
    rst = 1'b1; bus.restart = 1'b1; bus.div_load = 1'b1; bus.div_in = 16'd9;
    step();
    rst = 1'b0; bus.restart = 1'b0; bus.div_load = 1'b0;
    total++; if (bus.clk_out !== 1'b0 || bus.tick !== 1'b0 || bus.div_busy !== 1'b0) begin bad++; $display("FAIL rr_outs clk_out=%b tick=%b busy=%b exp=0,0,0", bus.clk_out, bus.tick, bus.div_busy); end
    total++; if (bus.div_cur !== 16'd4) begin bad++; $display("FAIL rr_div_cur got=%0d exp=4", bus.div_cur); end
    for (int s = 1; s <= 4; s++) step();
    total++; if (bus.clk_out !== 1'b1 || bus.div_cur !== 16'd4) begin bad++; $display("FAIL rr_after clk_out=%b div_cur=%0d exp=1,4", bus.clk_out, bus.div_cur); end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.restart = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;
    test_reset();
    test_basic();
    test_min_div();
    test_reload();
    test_double_load();
    test_enable_gating();
    test_restart_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock/tick divider. Parametrised successor of the fixed-constant toggle divider used for slow I/O clocks (LED scan, segment display, single-step clocks).
- Generates a 50%-duty divided clock and a one-cycle enable tick from the system clock.
- The divisor can be reloaded at runtime without glitches. The new value is applied only at a half-period boundary.
- Supports enable gating and a synchronous phase restart.

Parameters:
- DIV_W, 32, width of the divisor and the internal counter.
- DEFAULT_DIV, 10_000_000, half-period in clk cycles after reset. Values of 0 are clamped to 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; low freezes counter and outputs.
- restart  in  1  synchronous phase restart: counter=0, clk_out=0.
- div_load  in  1  one-cycle strobe; captures div_in.
- div_in  in  DIV_W  requested half-period in clk cycles.
- clk_out  out  1  divided clock, period 2*div_cur.
- tick  out  1  one-cycle pulse per half-period, coincident with each clk_out toggle.
- div_busy  out  1  high while a loaded divisor is pending.
- div_cur  out  DIV_W  divisor currently in effect.

Behaviour:
- Reset (rst=1 at an edge):
  - cnt=0, clk_out=0, tick=0, div_busy=0, pending cleared.
  - div_cur = max(DEFAULT_DIV, 1).
  - rst overrides all other inputs.
- Priority: rst > restart > en.
- Counting (en=1):
  - cnt increments each edge.
  - The edge where cnt==div_cur-1 is the boundary: cnt<=0, clk_out<=~clk_out, tick<=1.
  - tick<=0 on every other edge, and whenever en=0.
  - Latency: with divisor D, clk_out first rises D edges after reset is released with en=1.
  - tick is registered and high for exactly the cycle after each boundary edge.
- Divisor load:
  - div_load=1 captures clamp(div_in) = (div_in==0 ? 1 : div_in) into a pending register and sets div_busy=1 on that edge.
  - At the next boundary: div_cur<=pending, div_busy<=0. The new half-period starts from cnt=0.
  - div_load on the boundary edge itself: the value is applied directly at that boundary. div_busy stays 0.
  - div_load while already busy: the pending value is overwritten. Only the last load takes effect.
  - div_load with en=0: captured and pending; applied at the first boundary after en returns.
  - div_load while rst=1: ignored.
- Enable low:
  - cnt, clk_out, div_cur and pending are held; tick=0.
  - Resuming continues from the held cnt; no phase loss.
- Restart:
  - On that edge: cnt<=0, clk_out<=0, tick<=0.
  - Any pending divisor is applied immediately and div_busy<=0.
  - restart together with div_load: clamp(div_in) is applied immediately.
  - restart acts regardless of en.
- Divisor 1: clk_out toggles every edge (clk/2) and tick stays high continuously while en=1.
- Counter rule:
  - cnt width is DIV_W; cnt never exceeds div_cur-1.
  - Comparison is exact equality with div_cur-1; no wrap-around states are reachable.
- Reset mid-operation: all outputs return to reset values on the next edge, regardless of phase or pending load.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Basic divide: DEFAULT_DIV=4, rst 2 cycles, then en=1.
  - clk_out rises after edge 4 and falls after edge 8; period 8 clocks.
  - tick high exactly one cycle after edges 4, 8, 12.
  - div_cur=4.
- Minimum divisor: load div_in=1.
  - clk_out toggles every cycle; tick continuously 1.
  - div_in=0 gives the same result, with div_cur=1.
- Glitch-free reload: DIV=5, pulse div_load with div_in=3 at cnt=1.
  - div_busy=1 for 4 cycles; current half-period still lasts 5.
  - Following half-periods last 3; div_cur=3 after the boundary.
- Double load and boundary load:
  - Loads of 7 then 2 while busy: only 2 is applied.
  - Load issued on the boundary edge: applied immediately, div_busy never rises.
- Enable gating: DIV=4, en=0 for 3 cycles at cnt=2.
  - Next toggle is delayed by exactly 3 cycles.
  - tick=0 and clk_out held during the gap.
- Restart/reset precedence:
  - restart with div_load (div_in=6) mid-period: clk_out=0, cnt=0, div_cur=6, next rise after 6 edges.
  - rst with restart and div_load: full reset values, div_cur=DEFAULT_DIV.
